uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: entries per requester FIFO; power of two, 2..16.
REQ-002 Parameter BUSY_TIMEOUT, default 16: sysclk cycles to wait for tx_status to fall after a tx_en pulse.
REQ-003 sysclk  input  1  clock; all state is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low.
REQ-005 req0_data  input  8  byte from requester 0 (CPU core).
REQ-006 req0_wr  input  1  single-cycle push strobe for req0_data.
REQ-007 req0_full  output  1  requester 0 FIFO full.
REQ-008 req1_data  input  8  byte from requester 1 (debug/monitor).
REQ-009 req1_wr  input  1  single-cycle push strobe for req1_data.
REQ-010 req1_full  output  1  requester 1 FIFO full.
REQ-011 ovf_clr  input  1  clears both overflow flags.
REQ-012 ovf  output  2  sticky overflow flags; bit i is requester i.
REQ-013 tx_status  input  1  UART transmitter idle (1) or busy (0).
REQ-014 tx_en  output  1  single-cycle start strobe to the UART.
REQ-015 tx_data  output  8  byte presented to the UART; stable from the tx_en cycle until the next grant.
REQ-016 grant_id  output  1  requester whose byte is currently issued or in flight.
REQ-017 busy  output  1  high in every state other than IDLE.

Function
REQ-018 Each requester SHALL own one FIFO_DEPTH-entry synchronous FIFO; a push occurs when reqN_wr=1 and the FIFO is not full.
REQ-019 A push to a full FIFO SHALL be dropped and SHALL set ovf[N]; the FIFO contents SHALL be unchanged.
REQ-020 A simultaneous push and pop on the same FIFO SHALL both take effect, including when the FIFO is full.
REQ-021 ovf_clr SHALL clear ovf; if ovf_clr coincides with a new overflow on the same requester, the set SHALL win.
REQ-022 The FSM SHALL have four states: IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-023 IDLE: when tx_status=1 and at least one FIFO is non-empty, the FSM SHALL select a requester, pop one byte into tx_data, set grant_id, and go to ISSUE.
REQ-024 Selection SHALL be round-robin: if both FIFOs are non-empty, grant the requester not granted last; if only one is non-empty, grant that one.
REQ-025 ISSUE: tx_en SHALL be 1 for exactly this cycle, then the FSM SHALL go to WAIT_BUSY.
REQ-026 WAIT_BUSY: on tx_status=0 the FSM SHALL go to WAIT_DONE; after BUSY_TIMEOUT cycles without that, it SHALL go to IDLE with the byte counted as sent.
REQ-027 WAIT_DONE: on tx_status=1 the FSM SHALL go to IDLE.
REQ-028 Latency: a push in cycle N into an empty FIFO, with the FSM in IDLE and tx_status=1, SHALL give the pop and the ISSUE entry at edge N+1 and tx_en=1 in cycle N+2.
REQ-029 At most one tx_en SHALL occur per UART frame; no tx_en SHALL be issued while tx_status=0.
REQ-030 reqN_full SHALL be registered and SHALL reflect occupancy after the current cycle's push and pop.
REQ-031 The last-grant pointer SHALL update only on a grant.

Reset
REQ-032 Asserting reset at any time SHALL force the FSM to IDLE, empty both FIFOs, and discard any in-flight byte without re-sending it.
REQ-033 Reset values: tx_en=0, tx_data=8'h00, grant_id=0, busy=0, req0_full=0, req1_full=0, ovf=2'b00, last-grant pointer=1 (so requester 0 wins first).
REQ-034 Reset release SHALL be synchronised to sysclk before it reaches the FSM.

Structure
REQ-035 The shared package SHALL hold the FSM state encoding, the data width (8) and the requester count (2).
REQ-036 The FIFO SHALL be a single sub-module, byte_fifo, instantiated twice and parameterised by depth.
REQ-037 The arbiter SHALL run entirely on sysclk; a requester in a slower domain SHALL supply a one-sysclk-cycle wr pulse.

Verification
REQ-038 Single byte: push 8'h41 on req0 with tx_status=1 -> tx_en in cycle N+2, tx_data=8'h41, grant_id=0; UART model drops status for 10 cycles -> FSM returns to IDLE.
REQ-039 Contention: fill req0 with 01,02 and req1 with A1,A2 in the same cycles -> issue order 01,A1,02,A2.
REQ-040 Overflow: five pushes on req1 while tx_status=0 -> req1_full=1 after the fourth push, ovf=2'b10, and only four bytes are sent later; ovf_clr -> ovf=2'b00.
REQ-041 Timeout: tx_status held at 1 after tx_en -> return to IDLE after 16 cycles; the next byte is issued without duplication.
REQ-042 Reset mid-frame: reset asserted in WAIT_DONE with 3 bytes queued -> all reset values restored, no tx_en, and no queued byte sent after release.
REQ-043 Full push/pop: req0 full, pop and push in the same cycle -> req0_full stays 1, ovf[0] stays 0, and the byte order is preserved.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter.
package uart_tx_arbiter_pkg;

  localparam int DATA_W  = 8;
  localparam int NUM_REQ = 2;

  // FSM state encoding, kept as plain constants for legacy compatibility
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_tx_arbiter_byte_fifo.sv
// Synchronous byte FIFO with registered full/empty flags.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_next;
  logic              push;
  logic              pop;

  // Accept/drop decision and next occupancy
  always_comb begin
    pop        = rd && !empty;
    push       = wr && (!full || pop);
    overflow   = wr && full && !pop;
    count_next = count;
    if (push && !pop) begin
      count_next = count + (AW+1)'(1);
    end else if (pop && !push) begin
      count_next = count - (AW+1)'(1);
    end
  end

  // Pointers, occupancy and flags reflecting this cycle's push and pop
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage write
  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from two byte FIFOs.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_wr,
  output logic              req0_full,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_wr,
  output logic              req1_full,
  input  logic              ovf_clr,
  output logic [1:0]        ovf,
  input  logic              tx_status,
  output logic              tx_en,
  output logic [DATA_W-1:0] tx_data,
  output logic              grant_id,
  output logic              busy
);

  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

  logic [1:0]         rst_sync;
  logic               fsm_reset;
  logic [NUM_REQ-1:0] fifo_empty;
  logic [NUM_REQ-1:0] fifo_full;
  logic [NUM_REQ-1:0] fifo_ovf;
  logic [NUM_REQ-1:0] pop;
  logic [DATA_W-1:0]  head [NUM_REQ];
  logic [1:0]         state;
  logic [1:0]         state_next;
  logic               last_grant;
  logic               grant;
  logic               sel;
  logic [TO_W-1:0]    wait_cnt;

  // Reset synchroniser: asserts immediately, releases on sysclk
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign fsm_reset = rst_sync[1];

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
    .sysclk   (sysclk),
    .reset    (reset),
    .wr       (req0_wr),
    .din      (req0_data),
    .rd       (pop[0]),
    .dout     (head[0]),
    .full     (fifo_full[0]),
    .empty    (fifo_empty[0]),
    .overflow (fifo_ovf[0])
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .sysclk   (sysclk),
    .reset    (reset),
    .wr       (req1_wr),
    .din      (req1_data),
    .rd       (pop[1]),
    .dout     (head[1]),
    .full     (fifo_full[1]),
    .empty    (fifo_empty[1]),
    .overflow (fifo_ovf[1])
  );

  assign req0_full = fifo_full[0];
  assign req1_full = fifo_full[1];

  // Sticky overflow flags; a new overflow outranks a simultaneous clear
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) ovf <= 2'b00;
    else        ovf <= (ovf & ~{NUM_REQ{ovf_clr}}) | fifo_ovf;
  end

  // Next state, round-robin selection and FIFO pop.
  // Grants are held off while the synchronised reset is still asserted so a
  // popped byte is never lost to an FSM that cannot yet register it.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    sel        = last_grant;
    pop        = '0;
    case (state)
      ST_IDLE: begin
        if (fsm_reset && tx_status && (fifo_empty != '1)) begin
          grant      = 1'b1;
          sel        = (!fifo_empty[0] && !fifo_empty[1]) ? ~last_grant : fifo_empty[0];
          pop        = sel ? 2'b10 : 2'b01;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE:     state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!tx_status) begin
          state_next = ST_WAIT_DONE;
        end else if (wait_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_DONE: if (tx_status) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // FSM state, issued byte, grant owner and busy-timeout counter
  always_ff @(posedge sysclk or negedge fsm_reset) begin
    if (!fsm_reset) begin
      state      <= ST_IDLE;
      tx_data    <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        tx_data    <= sel ? head[1] : head[0];
        grant_id   <= sel;
        last_grant <= sel;
      end
      if (state == ST_WAIT_BUSY) wait_cnt <= wait_cnt + TO_W'(1);
      else                       wait_cnt <= '0;
    end
  end

  assign tx_en = (state == ST_ISSUE);
  assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a simple UART status model.
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic       gid;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic       req;
    logic [7:0] data;
    logic       exp_gid;
    logic [7:0] exp_data;
  } vec_t;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic [7:0] req0_data = '0;
  logic       req0_wr   = 1'b0;
  logic       req0_full;
  logic [7:0] req1_data = '0;
  logic       req1_wr   = 1'b0;
  logic       req1_full;
  logic       ovf_clr   = 1'b0;
  logic [1:0] ovf;
  logic       tx_status;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       grant_id;
  logic       busy;

  logic hold_low   = 1'b0;
  logic model_idle = 1'b1;
  logic stuck      = 1'b0;
  int   frame_left = 0;
  int   tx_count   = 0;
  int   passed     = 0;
  int   total      = 0;
  exp_t sb [$];

  assign tx_status = model_idle & ~hold_low;

  always #5 sysclk = ~sysclk;

  uart_tx_arbiter #(.FIFO_DEPTH(4), .BUSY_TIMEOUT(16)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .req0_data (req0_data),
    .req0_wr   (req0_wr),
    .req0_full (req0_full),
    .req1_data (req1_data),
    .req1_wr   (req1_wr),
    .req1_full (req1_full),
    .ovf_clr   (ovf_clr),
    .ovf       (ovf),
    .tx_status (tx_status),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge sysclk);
  endtask

  // UART model: scoreboard check on every tx_en, then status low for 10 cycles
  always @(negedge sysclk) begin
    exp_t e;
    if (tx_en) begin
      tx_count++;
      check("tx_en_with_status_idle", tx_status, 1);
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_tx_en: got id=%0d data=%02h, expected no transfer", grant_id, tx_data);
      end else begin
        e = sb.pop_front();
        check("sb_grant_id", grant_id, e.gid);
        check("sb_tx_data", tx_data, e.data);
      end
      if (!stuck) frame_left = 10;
    end
    if (frame_left > 0) begin
      model_idle = 1'b0;
      frame_left--;
    end else begin
      model_idle = 1'b1;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_en"},     tx_en,     0);
    check({tag, "_tx_data"},   tx_data,   8'h00);
    check({tag, "_grant_id"},  grant_id,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_req0_full"}, req0_full, 0);
    check({tag, "_req1_full"}, req1_full, 0);
    check({tag, "_ovf"},       ovf,       2'b00);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy || !tx_status) && n < 600) begin
      tick();
      n++;
    end
    check({tag, "_drain_done"}, (n < 600), 1);
  endtask

  task automatic push(input logic r, input logic [7:0] d);
    if (r) begin req1_wr = 1'b1; req1_data = d; end
    else   begin req0_wr = 1'b1; req0_data = d; end
    tick();
    req0_wr = 1'b0;
    req1_wr = 1'b0;
  endtask

  task automatic wait_tx_en(input string tag);
    int n = 0;
    while (!tx_en && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_tx_en_seen"}, tx_en, 1);
  endtask

  initial begin
    vec_t vecs [5];
    int   busy_cycles;
    int   cnt_before;

    vecs[0] = '{req: 1'b0, data: 8'h41, exp_gid: 1'b0, exp_data: 8'h41};
    vecs[1] = '{req: 1'b1, data: 8'h5A, exp_gid: 1'b1, exp_data: 8'h5A};
    vecs[2] = '{req: 1'b1, data: 8'h00, exp_gid: 1'b1, exp_data: 8'h00};
    vecs[3] = '{req: 1'b0, data: 8'hFF, exp_gid: 1'b0, exp_data: 8'hFF};
    vecs[4] = '{req: 1'b0, data: 8'h3C, exp_gid: 1'b0, exp_data: 8'h3C};

    // Reset state
    repeat (3) tick();
    check_reset_values("rst");
    reset = 1'b1;
    repeat (4) tick();

    // Contention straight after reset: requester 0 wins first, then alternation
    sb.push_back('{gid: 1'b0, data: 8'h01});
    sb.push_back('{gid: 1'b1, data: 8'hA1});
    sb.push_back('{gid: 1'b0, data: 8'h02});
    sb.push_back('{gid: 1'b1, data: 8'hA2});
    req0_wr = 1'b1; req0_data = 8'h01; req1_wr = 1'b1; req1_data = 8'hA1;
    tick();
    req0_data = 8'h02; req1_data = 8'hA2;
    tick();
    req0_wr = 1'b0; req1_wr = 1'b0;
    wait_drain("contention");

    // Single-byte table: latency, grant id and data
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{gid: vecs[i].exp_gid, data: vecs[i].exp_data});
      push(vecs[i].req, vecs[i].data);
      check("vec_tx_en_n1", tx_en, 0);
      tick();
      check("vec_tx_en_n2", tx_en, 1);
      check("vec_grant_id", grant_id, vecs[i].exp_gid);
      check("vec_tx_data", tx_data, vecs[i].exp_data);
      check("vec_busy", busy, 1);
      wait_drain("vec");
    end

    // Overflow on requester 1 while the UART is busy
    hold_low = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(1'b1, 8'hB1 + 8'(k));
      check("ovf_req1_full", req1_full, (k >= 3));
      if (k == 3) check("ovf_before_fifth", ovf, 2'b00);
    end
    check("ovf_after_fifth", ovf, 2'b10);
    for (int k = 0; k < 4; k++) sb.push_back('{gid: 1'b1, data: 8'hB1 + 8'(k)});
    hold_low = 1'b0;
    wait_drain("ovf");
    check("ovf_sticky", ovf, 2'b10);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 2'b00);

    // Overflow coinciding with clear: the set wins
    hold_low = 1'b1;
    for (int k = 0; k < 4; k++) push(1'b0, 8'hC1 + 8'(k));
    ovf_clr = 1'b1;
    push(1'b0, 8'hC5);
    ovf_clr = 1'b0;
    check("ovf_set_wins", ovf, 2'b01);
    for (int k = 0; k < 4; k++) sb.push_back('{gid: 1'b0, data: 8'hC1 + 8'(k)});
    hold_low = 1'b0;
    wait_drain("setwins");
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared2", ovf, 2'b00);

    // Busy timeout: status never drops after tx_en
    stuck = 1'b1;
    sb.push_back('{gid: 1'b0, data: 8'hD1});
    push(1'b0, 8'hD1);
    wait_tx_en("timeout");
    busy_cycles = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (!busy) break;
      busy_cycles++;
    end
    check("timeout_wait_cycles", busy_cycles, 16);
    stuck = 1'b0;
    sb.push_back('{gid: 1'b0, data: 8'hD2});
    push(1'b0, 8'hD2);
    wait_drain("timeout");

    // Reset asserted mid-frame with three bytes queued
    sb.push_back('{gid: 1'b0, data: 8'hE1});
    push(1'b0, 8'hE1);
    wait_tx_en("midreset");
    tick();
    push(1'b0, 8'hE2);
    push(1'b0, 8'hE3);
    push(1'b0, 8'hE4);
    check("midreset_in_frame", {busy, tx_status}, 2'b10);
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (3) tick();
    reset = 1'b1;
    cnt_before = tx_count;
    repeat (40) tick();
    check("midreset_no_resend", tx_count, cnt_before);
    check("midreset_req0_full", req0_full, 0);

    // Full FIFO: pop and push in the same cycle
    wait_drain("prefull");
    hold_low = 1'b1;
    for (int k = 0; k < 4; k++) push(1'b0, 8'hF1 + 8'(k));
    check("fullpp_full_before", req0_full, 1);
    for (int k = 0; k < 5; k++) sb.push_back('{gid: 1'b0, data: 8'hF1 + 8'(k)});
    hold_low = 1'b0;
    push(1'b0, 8'hF5);
    check("fullpp_full_kept", req0_full, 1);
    check("fullpp_no_ovf", ovf[0], 0);
    wait_drain("fullpp");

    check("total_tx_count", tx_count, 25);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
